rsa_job_sched: RTL and testbench

RSA_JOB_SCHED -- requirements
Module: rsa_job_sched

---
 rtl/rsa_job_sched.sv | 136 +++++++++++++
 tb/tb_rsa_job_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_sched.sv
// Job scheduler for a modexp engine: tracks 32 queued (n,d,c) triples, sequences
// fetch/start/wait per job, times out stalled jobs and holds results for the consumer.
module rsa_job_sched #(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         wr_en,
    output logic [4:0]   wr_addr,
    output logic [4:0]   rd_addr,
    output logic         eng_start,
    input  logic         eng_done,
    input  logic [W-1:0] eng_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [4:0]   res_tag,
    input  logic         flush,
    output logic [5:0]   job_count,
    output logic         err_timeout,
    output logic         err_spurious
);

    localparam logic [5:0]    FULL  = 6'd32;
    localparam int unsigned   TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [4:0]    wr_ptr;
    logic [4:0]    rd_ptr;
    logic [TW-1:0] timer;
    logic          timeout;
    logic          handshake;
    logic          retire;
    logic          capture;

    assign in_ready  = (job_count != FULL) && !flush;
    assign wr_en     = in_valid && in_ready;
    assign wr_addr   = wr_ptr;
    assign rd_addr   = rd_ptr;
    assign eng_start = (state == S_START) && !flush;
    assign res_valid = (state == S_OUT);

    // eng_done beats expiry, so timeout is only taken in a cycle without eng_done
    assign timeout   = (state == S_WAIT) && !eng_done && (timer == TLAST) && !flush;
    assign handshake = (state == S_OUT) && res_ready && !flush;
    assign retire    = timeout || handshake;
    assign capture   = (state == S_WAIT) && eng_done && !flush;

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (job_count != 6'd0) state_next = S_FETCH;
                S_FETCH: state_next = S_START;
                S_START: state_next = S_WAIT;
                S_WAIT: begin
                    if (eng_done)     state_next = S_OUT;
                    else if (timeout) state_next = S_IDLE;
                end
                // post-retire count is job_count - 1 + wr_en
                S_OUT: begin
                    if (res_ready)
                        state_next = ((job_count != 6'd1) || wr_en) ? S_FETCH : S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            job_count <= '0;
            timer     <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            job_count <= '0;
            timer     <= '0;
        end else begin
            state <= state_next;
            if (wr_en)  wr_ptr <= wr_ptr + 5'd1;
            if (retire) rd_ptr <= rd_ptr + 5'd1;
            case ({wr_en, retire})
                2'b10:   job_count <= job_count + 6'd1;
                2'b01:   job_count <= job_count - 6'd1;
                default: job_count <= job_count;
            endcase
            if (state == S_WAIT) timer <= timer + 1'b1;
            else                 timer <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_tag  <= '0;
        end else if (capture) begin
            res_data <= eng_result;
            res_tag  <= rd_ptr;
        end
    end

    // error flags survive flush; only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (timeout)                       err_timeout  <= 1'b1;
            if (eng_done && (state != S_WAIT)) err_spurious <= 1'b1;
        end
    end

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) job_count <= FULL);
    a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && (job_count == FULL)));

endmodule

// File: tb/tb_rsa_job_sched.sv
// Directed self-checking bench for rsa_job_sched; a second instance with a short
// timeout exercises the expiry path.
module tb_rsa_job_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        in_valid, in_ready, wr_en, eng_start, eng_done, res_valid, res_ready, flush;
    logic        err_timeout, err_spurious;
    logic [4:0]  wr_addr, rd_addr, res_tag;
    logic [31:0] eng_result, res_data;
    logic [5:0]  job_count;

    logic        t_in_valid, t_in_ready, t_wr_en, t_eng_start, t_eng_done, t_res_valid, t_res_ready, t_flush;
    logic        t_err_timeout, t_err_spurious;
    logic [4:0]  t_wr_addr, t_rd_addr, t_res_tag;
    logic [31:0] t_eng_result, t_res_data;
    logic [5:0]  t_job_count;

    always #5 clk = ~clk;

    rsa_job_sched #(.W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .eng_start(eng_start),
        .eng_done(eng_done), .eng_result(eng_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag), .flush(flush),
        .job_count(job_count), .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    rsa_job_sched #(.W(32), .TIMEOUT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .wr_en(t_wr_en), .wr_addr(t_wr_addr), .rd_addr(t_rd_addr), .eng_start(t_eng_start),
        .eng_done(t_eng_done), .eng_result(t_eng_result), .res_valid(t_res_valid),
        .res_ready(t_res_ready), .res_data(t_res_data), .res_tag(t_res_tag), .flush(t_flush),
        .job_count(t_job_count), .err_timeout(t_err_timeout), .err_spurious(t_err_spurious)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; eng_done = 0; res_ready = 0; flush = 0; eng_result = '0;
        t_in_valid = 0; t_eng_done = 0; t_res_ready = 0; t_flush = 0; t_eng_result = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (job_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", job_count); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %b exp 0", eng_start); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (wr_addr !== 5'd0 || rd_addr !== 5'd0) begin errors++; $display("FAIL reset_ptrs: got wr %0d rd %0d exp 0 0", wr_addr, rd_addr); end
        checks++; if (res_data !== 32'd0 || err_timeout !== 1'b0 || err_spurious !== 1'b0) begin errors++; $display("FAIL reset_regs: got data %h errs %b%b exp 0 00", res_data, err_timeout, err_spurious); end
        rst_n = 1'b1;
        step();
        checks++; if (eng_start !== 1'b0 || job_count !== 6'd0) begin errors++; $display("FAIL reset_first_edge: got start %b count %0d exp 0 0", eng_start, job_count); end
    endtask

    task automatic test_single_job();
        int starts;
        in_valid = 1; #1;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd0) begin errors++; $display("FAIL single_write: got wr_en %b addr %0d exp 1 0", wr_en, wr_addr); end
        step(); in_valid = 0;
        checks++; if (job_count !== 6'd1 || wr_addr !== 5'd1) begin errors++; $display("FAIL single_count: got %0d addr %0d exp 1 1", job_count, wr_addr); end
        step();
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL single_fetch_start: got %b exp 0", eng_start); end
        step();
        checks++; if (eng_start !== 1'b1 || rd_addr !== 5'd0) begin errors++; $display("FAIL single_start: got %b rd %0d exp 1 0", eng_start, rd_addr); end
        starts = 0;
        repeat (10) begin step(); if (eng_start) starts++; end
        checks++; if (starts !== 0) begin errors++; $display("FAIL single_wait_starts: got %0d exp 0", starts); end
        eng_done = 1; eng_result = 32'h1234ABCD;
        step(); eng_done = 0;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h1234ABCD) begin errors++; $display("FAIL single_result: got v %b data %h exp 1 1234abcd", res_valid, res_data); end
        checks++; if (res_tag !== 5'd0 || job_count !== 6'd1) begin errors++; $display("FAIL single_tag: got tag %0d count %0d exp 0 1", res_tag, job_count); end
        res_ready = 1;
        step(); res_ready = 0;
        checks++; if (res_valid !== 1'b0 || job_count !== 6'd0 || rd_addr !== 5'd1) begin errors++; $display("FAIL single_retire: got v %b count %0d rd %0d exp 0 0 1", res_valid, job_count, rd_addr); end
    endtask

    task automatic test_backpressure();
        int bad;
        in_valid = 1; step(); in_valid = 0;
        step(); step();
        checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL bp_start: got %b exp 1", eng_start); end
        step(); eng_done = 1; eng_result = 32'hCAFEF00D;
        step(); eng_done = 0;
        in_valid = 1; #1;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd2) begin errors++; $display("FAIL bp_write_in_out: got wr_en %b addr %0d exp 1 2", wr_en, wr_addr); end
        step(); in_valid = 0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b1 || res_data !== 32'hCAFEF00D || res_tag !== 5'd1 || eng_start !== 1'b0) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles exp 0", bad); end
        checks++; if (job_count !== 6'd2 || res_data !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_count: got %0d data %h exp 2 cafef00d", job_count, res_data); end
        res_ready = 1; step(); res_ready = 0;
        checks++; if (res_valid !== 1'b0 || job_count !== 6'd1 || rd_addr !== 5'd2 || eng_start !== 1'b0) begin errors++; $display("FAIL bp_retire: got v %b count %0d rd %0d st %b exp 0 1 2 0", res_valid, job_count, rd_addr, eng_start); end
        step();
        checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL bp_next_start: got %b exp 1", eng_start); end
        step(); eng_done = 1; eng_result = 32'h00000777;
        step(); eng_done = 0;
        checks++; if (res_tag !== 5'd2 || res_data !== 32'h00000777) begin errors++; $display("FAIL bp_second: got tag %0d data %h exp 2 00000777", res_tag, res_data); end
        res_ready = 1; step(); res_ready = 0;
        step(); step();
        checks++; if (job_count !== 6'd0 || eng_start !== 1'b0) begin errors++; $display("FAIL bp_drain: got count %0d st %b exp 0 0", job_count, eng_start); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1; step(); in_valid = 0;
        step(); step();
        step(); eng_done = 1; eng_result = 32'hA5A50001;
        step(); eng_done = 0;
        checks++; if (res_valid !== 1'b1 || res_tag !== 5'd3) begin errors++; $display("FAIL b2b_out: got v %b tag %0d exp 1 3", res_valid, res_tag); end
        res_ready = 1; in_valid = 1; #1;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd4) begin errors++; $display("FAIL b2b_write: got wr_en %b addr %0d exp 1 4", wr_en, wr_addr); end
        step(); res_ready = 0; in_valid = 0;
        checks++; if (job_count !== 6'd1 || rd_addr !== 5'd4 || res_valid !== 1'b0) begin errors++; $display("FAIL b2b_count: got count %0d rd %0d v %b exp 1 4 0", job_count, rd_addr, res_valid); end
        step();
        checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL b2b_fetch_start: got %b exp 1", eng_start); end
        step(); eng_done = 1; eng_result = 32'hA5A50002;
        step(); eng_done = 0;
        checks++; if (res_tag !== 5'd4 || res_data !== 32'hA5A50002) begin errors++; $display("FAIL b2b_second: got tag %0d data %h exp 4 a5a50002", res_tag, res_data); end
        res_ready = 1; step(); res_ready = 0;
        checks++; if (job_count !== 6'd0) begin errors++; $display("FAIL b2b_drain: got %0d exp 0", job_count); end
    endtask

    task automatic test_full_wrap_flush();
        int bad;
        flush = 1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
        step(); flush = 0;
        checks++; if (wr_addr !== 5'd0 || rd_addr !== 5'd0 || job_count !== 6'd0) begin errors++; $display("FAIL flush_ptrs: got wr %0d rd %0d count %0d exp 0 0 0", wr_addr, rd_addr, job_count); end
        in_valid = 1; #1;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (wr_en !== 1'b1 || wr_addr !== 5'(i)) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_writes: got %0d bad writes exp 0", bad); end
        checks++; if (job_count !== 6'd32 || in_ready !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL full_state: got count %0d rdy %b wr_en %b exp 32 0 0", job_count, in_ready, wr_en); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL full_wrap_addr: got %0d exp 0", wr_addr); end
        in_valid = 0; eng_done = 1; eng_result = 32'hF00D0000;
        step(); eng_done = 0;
        checks++; if (res_valid !== 1'b1 || res_tag !== 5'd0 || res_data !== 32'hF00D0000) begin errors++; $display("FAIL full_result: got v %b tag %0d data %h exp 1 0 f00d0000", res_valid, res_tag, res_data); end
        res_ready = 1; step(); res_ready = 0;
        checks++; if (job_count !== 6'd31 || in_ready !== 1'b1 || rd_addr !== 5'd1) begin errors++; $display("FAIL full_retire: got count %0d rdy %b rd %0d exp 31 1 1", job_count, in_ready, rd_addr); end
        in_valid = 1; #1;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd0) begin errors++; $display("FAIL full_reuse: got wr_en %b addr %0d exp 1 0", wr_en, wr_addr); end
        step(); in_valid = 0;
        checks++; if (job_count !== 6'd32 || wr_addr !== 5'd1 || eng_start !== 1'b1) begin errors++; $display("FAIL full_refill: got count %0d wr %0d st %b exp 32 1 1", job_count, wr_addr, eng_start); end
        step(); flush = 1; #1;
        checks++; if (eng_start !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_wait: got st %b rdy %b exp 0 0", eng_start, in_ready); end
        step(); flush = 0;
        checks++; if (job_count !== 6'd0 || wr_addr !== 5'd0 || rd_addr !== 5'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got count %0d wr %0d rd %0d v %b exp 0 0 0 0", job_count, wr_addr, rd_addr, res_valid); end
        bad = 0;
        repeat (4) begin step(); if (eng_start !== 1'b0) bad++; end
        checks++; if (bad !== 0 || err_spurious !== 1'b0) begin errors++; $display("FAIL flush_idle: got starts %0d spur %b exp 0 0", bad, err_spurious); end
        eng_done = 1; step(); eng_done = 0;
        checks++; if (err_spurious !== 1'b1 || err_timeout !== 1'b0 || job_count !== 6'd0) begin errors++; $display("FAIL spurious: got spur %b to %b count %0d exp 1 0 0", err_spurious, err_timeout, job_count); end
    endtask

    task automatic test_reset_mid_out();
        in_valid = 1; step(); in_valid = 0;
        step(); step();
        step(); eng_done = 1; eng_result = 32'hDEADBEEF;
        step(); eng_done = 0;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_pre_out: got v %b data %h exp 1 deadbeef", res_valid, res_data); end
        rst_n = 0; #1;
        checks++; if (res_valid !== 1'b0 || res_data !== 32'd0 || res_tag !== 5'd0) begin errors++; $display("FAIL rst_out_clear: got v %b data %h tag %0d exp 0 0 0", res_valid, res_data, res_tag); end
        checks++; if (job_count !== 6'd0 || wr_addr !== 5'd0 || err_spurious !== 1'b0 || eng_start !== 1'b0) begin errors++; $display("FAIL rst_out_state: got count %0d wr %0d spur %b st %b exp 0 0 0 0", job_count, wr_addr, err_spurious, eng_start); end
        step(); rst_n = 1;
        step(); eng_done = 1; step(); eng_done = 0;
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL rst_late_done: got %b exp 1", err_spurious); end
    endtask

    task automatic test_timeout();
        int bad;
        t_in_valid = 1; step(); t_in_valid = 0;
        step(); step();
        checks++; if (t_eng_start !== 1'b1) begin errors++; $display("FAIL to_start0: got %b exp 1", t_eng_start); end
        repeat (8) step();
        t_eng_done = 1; t_eng_result = 32'h0BADCAFE;
        step(); t_eng_done = 0;
        checks++; if (t_res_valid !== 1'b1 || t_res_data !== 32'h0BADCAFE || t_err_timeout !== 1'b0) begin errors++; $display("FAIL to_expiry_done: got v %b data %h to %b exp 1 0badcafe 0", t_res_valid, t_res_data, t_err_timeout); end
        t_res_ready = 1; step(); t_res_ready = 0;
        checks++; if (t_job_count !== 6'd0) begin errors++; $display("FAIL to_drain0: got %0d exp 0", t_job_count); end
        t_in_valid = 1; step(); step(); t_in_valid = 0;
        step();
        checks++; if (t_eng_start !== 1'b1 || t_rd_addr !== 5'd1 || t_job_count !== 6'd2) begin errors++; $display("FAIL to_start1: got st %b rd %0d count %0d exp 1 1 2", t_eng_start, t_rd_addr, t_job_count); end
        bad = 0;
        repeat (8) begin step(); if (t_err_timeout !== 1'b0 || t_job_count !== 6'd2) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_early: got %0d early cycles exp 0", bad); end
        step();
        checks++; if (t_err_timeout !== 1'b1 || t_job_count !== 6'd1 || t_rd_addr !== 5'd2 || t_res_valid !== 1'b0) begin errors++; $display("FAIL to_expire: got to %b count %0d rd %0d v %b exp 1 1 2 0", t_err_timeout, t_job_count, t_rd_addr, t_res_valid); end
        step();
        checks++; if (t_eng_start !== 1'b0) begin errors++; $display("FAIL to_fetch: got %b exp 0", t_eng_start); end
        step();
        checks++; if (t_eng_start !== 1'b1) begin errors++; $display("FAIL to_next_start: got %b exp 1", t_eng_start); end
        t_flush = 1; step(); t_flush = 0;
        checks++; if (t_job_count !== 6'd0 || t_err_timeout !== 1'b1) begin errors++; $display("FAIL to_flush_sticky: got count %0d to %b exp 0 1", t_job_count, t_err_timeout); end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_backpressure();
        test_back_to_back();
        test_full_wrap_flush();
        test_reset_mid_out();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
